// File: rtl/xbar_pkg.sv
// Shared types and constants for the 2x2 crossbar router.
//   NUM_PORTS  : number of inputs and outputs
//   MAX_WIDTH  : widest payload a beat_t can carry (WIDTH must not exceed it)
//   port_idx_t : 1-bit input/output port index
//   beat_t     : one held beat {data, src}
package xbar_pkg;

    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned MAX_WIDTH = 64;

    typedef logic port_idx_t;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] data;
        port_idx_t            src;
    } beat_t;

    // Round-robin pointer moves to whichever input was not just served.
    function automatic port_idx_t other_port(input port_idx_t p);
        return port_idx_t'(~p);
    endfunction

endpackage

// File: rtl/xbar_out_port.sv
// One crossbar output: request decode, round-robin pointer, grant and a
// one-entry output register.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_dest   : per-input valid and destination
//   in0_data, in1_data  : per-input payload
//   out_ready           : sink consumes the held beat
//   out_valid/data/src  : registered output beat
//   grant_c             : combinational one-hot grant per input
module xbar_out_port
    import xbar_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter port_idx_t   PORT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] in_valid,
    input  logic [NUM_PORTS-1:0] in_dest,
    input  logic [WIDTH-1:0]     in0_data,
    input  logic [WIDTH-1:0]     in1_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output port_idx_t            out_src,
    output logic [NUM_PORTS-1:0] grant_c
);

    logic                 valid_q, valid_d;
    beat_t                beat_q,  beat_d;
    port_idx_t            ptr_q,   ptr_d;
    logic [NUM_PORTS-1:0] req_c;
    logic                 can_load_c;
    port_idx_t            win_c;
    logic                 unused_hi;

    // Request decode and arbitration; no grants are issued during reset.
    always_comb begin
        req_c[0]   = in_valid[0] && (in_dest[0] == PORT);
        req_c[1]   = in_valid[1] && (in_dest[1] == PORT);
        can_load_c = !valid_q || out_ready;
        grant_c    = '0;
        if (!rst && can_load_c) begin
            if (&req_c) begin
                grant_c[ptr_q] = 1'b1;
            end else begin
                grant_c = req_c;
            end
        end
        win_c = port_idx_t'(grant_c[1]);
    end

    // Next-state for the output register and pointer.
    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        ptr_d   = ptr_q;
        if (|grant_c) begin
            valid_d     = 1'b1;
            beat_d.data = MAX_WIDTH'(win_c ? in1_data : in0_data);
            beat_d.src  = win_c;
            ptr_d       = other_port(win_c);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
            ptr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = WIDTH'(beat_q.data);
    assign out_src   = beat_q.src;

    // Bits above WIDTH are always zero-loaded and never observed.
    assign unused_hi = ^beat_q.data;

endmodule

// File: rtl/xbar_router.sv
// 2x2 valid/ready crossbar router with per-output round-robin arbitration
// and one-cycle registered latency.
//   clk, rst                      : clock, synchronous active-high reset
//   inN_valid/dest/data, inN_ready: source N handshake (ready combinational)
//   outK_valid/data/src, outK_ready: sink K handshake (outputs registered)
module xbar_router
    import xbar_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic             in0_dest,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic             in1_dest,
    input  logic [WIDTH-1:0] in1_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_src,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_src
);

    logic [NUM_PORTS-1:0] valid_w;
    logic [NUM_PORTS-1:0] dest_w;
    logic [NUM_PORTS-1:0] o_ready_w;
    logic [NUM_PORTS-1:0] o_valid_w;
    logic [WIDTH-1:0]     o_data_w  [NUM_PORTS];
    port_idx_t            o_src_w   [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant_w   [NUM_PORTS];

    assign valid_w   = {in1_valid, in0_valid};
    assign dest_w    = {in1_dest, in0_dest};
    assign o_ready_w = {out1_ready, out0_ready};

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_out
        xbar_out_port #(
            .WIDTH (WIDTH),
            .PORT  (port_idx_t'(k))
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (valid_w),
            .in_dest   (dest_w),
            .in0_data  (in0_data),
            .in1_data  (in1_data),
            .out_ready (o_ready_w[k]),
            .out_valid (o_valid_w[k]),
            .out_data  (o_data_w[k]),
            .out_src   (o_src_w[k]),
            .grant_c   (grant_w[k])
        );
    end

    // An input is accepted by whichever output granted it (at most one).
    assign in0_ready = grant_w[0][0] | grant_w[1][0];
    assign in1_ready = grant_w[0][1] | grant_w[1][1];

    assign out0_valid = o_valid_w[0];
    assign out0_data  = o_data_w[0];
    assign out0_src   = o_src_w[0];
    assign out1_valid = o_valid_w[1];
    assign out1_data  = o_data_w[1];
    assign out1_src   = o_src_w[1];

endmodule

// File: tb/tb_xbar_router.sv
// Self-checking bench for xbar_router: directed scenarios plus a randomized
// run against a behavioural model and per-(source,output) order scoreboard.
module tb_xbar_router;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in0_valid = 1'b0, in1_valid = 1'b0;
    logic         in0_dest = 1'b0, in1_dest = 1'b0;
    logic [W-1:0] in0_data = '0, in1_data = '0;
    logic         in0_ready, in1_ready;
    logic         out0_valid, out1_valid;
    logic         out0_ready = 1'b0, out1_ready = 1'b0;
    logic [W-1:0] out0_data, out1_data;
    logic         out0_src, out1_src;

    int checks   = 0;
    int failures = 0;

    xbar_router #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in0_valid  (in0_valid),
        .in0_ready  (in0_ready),
        .in0_dest   (in0_dest),
        .in0_data   (in0_data),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .in1_dest   (in1_dest),
        .in1_data   (in1_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_src   (out0_src),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_src   (out1_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic d0, input logic [W-1:0] x0,
                         input logic v1, input logic d1, input logic [W-1:0] x1,
                         input logic r0, input logic r1);
        in0_valid = v0; in0_dest = d0; in0_data = x0;
        in1_valid = v1; in1_dest = d1; in1_data = x1;
        out0_ready = r0; out1_ready = r1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 0, 32'h1, 1, 1, 32'h2, 1, 1);
        #2;
        checks++; if (in0_ready !== 1'b0) begin failures++; $display("FAIL reset_in0_ready got=%b exp=0", in0_ready); end
        checks++; if (in1_ready !== 1'b0) begin failures++; $display("FAIL reset_in1_ready got=%b exp=0", in1_ready); end
        tick(); tick();
        checks++; if ({out1_valid, out0_valid} !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", {out1_valid, out0_valid}); end
        checks++; if (out0_data !== '0 || out1_data !== '0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", out0_data, out1_data); end
        checks++; if ({out1_src, out0_src} !== 2'b00) begin failures++; $display("FAIL reset_src got=%b exp=00", {out1_src, out0_src}); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        drive(1, 1, 32'hA5A5A5A5, 0, 0, 0, 0, 1);
        #2;
        checks++; if ({in1_ready, in0_ready} !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", {in1_ready, in0_ready}); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checks++; if (out1_valid !== 1'b1 || out1_data !== 32'hA5A5A5A5 || out1_src !== 1'b0)
            begin failures++; $display("FAIL single_out1 got=%b/%h/%b exp=1/a5a5a5a5/0", out1_valid, out1_data, out1_src); end
        checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL single_out0_idle got=%b exp=0", out0_valid); end
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", out1_valid); end
    endtask

    task automatic test_contention();
        logic [W-1:0] exp_d;
        for (int j = 0; j < 4; j++) begin
            drive(1, 0, 32'h11, 1, 0, 32'h22, 1, 0);
            #2;
            checks++; if (in0_ready !== (j % 2 == 0) || in1_ready !== (j % 2 == 1))
                begin failures++; $display("FAIL contention_ready[%0d] got=%b%b exp=%b%b", j, in1_ready, in0_ready, j % 2 == 1, j % 2 == 0); end
            tick();
            exp_d = (j % 2 == 0) ? 32'h11 : 32'h22;
            checks++; if (out0_valid !== 1'b1 || out0_data !== exp_d || out0_src !== 1'(j % 2))
                begin failures++; $display("FAIL contention_out[%0d] got=%b/%h/%b exp=1/%h/%0d", j, out0_valid, out0_data, out0_src, exp_d, j % 2); end
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        tick();
    endtask

    task automatic test_parallel();
        drive(1, 0, 32'h33, 1, 1, 32'h44, 1, 1);
        #2;
        checks++; if ({in1_ready, in0_ready} !== 2'b11) begin failures++; $display("FAIL parallel_ready got=%b exp=11", {in1_ready, in0_ready}); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        checks++; if (out0_valid !== 1'b1 || out0_data !== 32'h33 || out0_src !== 1'b0)
            begin failures++; $display("FAIL parallel_out0 got=%b/%h/%b exp=1/33/0", out0_valid, out0_data, out0_src); end
        checks++; if (out1_valid !== 1'b1 || out1_data !== 32'h44 || out1_src !== 1'b1)
            begin failures++; $display("FAIL parallel_out1 got=%b/%h/%b exp=1/44/1", out1_valid, out1_data, out1_src); end
        tick();
    endtask

    task automatic test_back_pressure();
        drive(1, 0, 32'h55, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 32'h66, 0, 0, 0, 0, 0);
        for (int j = 0; j < 5; j++) begin
            #2;
            checks++; if (in0_ready !== 1'b0 || out0_valid !== 1'b1 || out0_data !== 32'h55)
                begin failures++; $display("FAIL stall[%0d] got=rdy%b/%b/%h exp=rdy0/1/55", j, in0_ready, out0_valid, out0_data); end
            tick();
        end
        out0_ready = 1'b1;
        #2;
        checks++; if (in0_ready !== 1'b1) begin failures++; $display("FAIL refill_ready got=%b exp=1", in0_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        checks++; if (out0_valid !== 1'b1 || out0_data !== 32'h66)
            begin failures++; $display("FAIL refill_out0 got=%b/%h exp=1/66", out0_valid, out0_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 32'h70, 1, 1, 32'h77, 0, 0);
        tick();
        drive(0, 0, 0, 1, 1, 32'h78, 0, 1);
        rst = 1'b1;
        #2;
        checks++; if (in1_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_ready got=%b exp=0", in1_ready); end
        tick();
        #2;
        checks++; if (out1_valid !== 1'b0 || out0_valid !== 1'b0 || in1_ready !== 1'b0)
            begin failures++; $display("FAIL rst_mid_state got=v%b%b rdy%b exp=v00 rdy0", out1_valid, out0_valid, in1_ready); end
        rst = 1'b0;
        drive(1, 0, 32'h81, 1, 0, 32'h82, 1, 1);
        #2;
        checks++; if ({in1_ready, in0_ready} !== 2'b01) begin failures++; $display("FAIL rst_first_grant got=%b exp=01", {in1_ready, in0_ready}); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        checks++; if (out0_data !== 32'h81 || out0_src !== 1'b0)
            begin failures++; $display("FAIL rst_first_out got=%h/%b exp=81/0", out0_data, out0_src); end
        tick();
    endtask

    // Model: per output a held beat (or empty) and a favoured input; the
    // scoreboard keeps accepted payloads per (source, output) in order.
    task automatic test_random();
        bit           m_full [2];
        logic [W-1:0] m_data [2];
        bit           m_src  [2];
        bit           m_ptr  [2];
        logic [W-1:0] sb [4][$];
        bit           v [2], d [2], r [2];
        logic [W-1:0] x [2];
        int           winner [2];
        bit           rdy [2], ov [2], os [2];
        logic [W-1:0] od [2];
        logic [W-1:0] front;
        int           nreq;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 0; m_data[k] = '0; m_src[k] = 0; m_ptr[k] = 0;
        end

        for (int cyc = 0; cyc < 10040; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                v[i] = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
                d[i] = 1'($urandom_range(0, 1));
                x[i] = $urandom;
                r[i] = (cyc < 10000) ? ($urandom_range(0, 9) < 7) : 1'b1;
            end
            drive(v[0], d[0], x[0], v[1], d[1], x[1], r[0], r[1]);
            #2;
            rdy[0] = in0_ready; rdy[1] = in1_ready;
            ov[0] = out0_valid; ov[1] = out1_valid;
            od[0] = out0_data;  od[1] = out1_data;
            os[0] = out0_src;   os[1] = out1_src;

            // Who each output should serve this cycle.
            for (int k = 0; k < 2; k++) begin
                nreq = 0;
                winner[k] = -1;
                for (int i = 0; i < 2; i++) if (v[i] && d[i] == k) begin nreq++; winner[k] = i; end
                if (m_full[k] && !r[k]) winner[k] = -1;
                else if (nreq == 2) winner[k] = int'(m_ptr[k]);
            end

            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rdy[i] !== (v[i] && winner[d[i]] == i))
                    begin failures++; $display("FAIL rand_ready%0d cyc=%0d got=%b exp=%b", i, cyc, rdy[i], v[i] && winner[d[i]] == i); end
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (ov[k] !== m_full[k] || (m_full[k] && (od[k] !== m_data[k] || os[k] !== m_src[k])))
                    begin failures++; $display("FAIL rand_out%0d cyc=%0d got=%b/%h/%b exp=%b/%h/%b", k, cyc, ov[k], od[k], os[k], m_full[k], m_data[k], m_src[k]); end
                if (ov[k] && r[k]) begin
                    checks++;
                    if (sb[os[k]*2 + k].size() == 0) begin
                        failures++; $display("FAIL rand_dup%0d cyc=%0d got=%h exp=none", k, cyc, od[k]);
                    end else begin
                        front = sb[os[k]*2 + k].pop_front();
                        if (od[k] !== front) begin failures++; $display("FAIL rand_order%0d cyc=%0d got=%h exp=%h", k, cyc, od[k], front); end
                    end
                end
            end
            for (int i = 0; i < 2; i++) if (rdy[i] && v[i]) sb[i*2 + int'(d[i])].push_back(x[i]);

            for (int k = 0; k < 2; k++) begin
                if (winner[k] >= 0) begin
                    m_full[k] = 1; m_data[k] = x[winner[k]]; m_src[k] = 1'(winner[k]);
                    m_ptr[k] = 1'(1 - winner[k]);
                end else if (r[k]) begin
                    m_full[k] = 0;
                end
            end
            tick();
        end

        for (int q = 0; q < 4; q++) begin
            checks++;
            if (sb[q].size() != 0) begin failures++; $display("FAIL rand_loss q=%0d got=%0d exp=0", q, sb[q].size()); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_parallel();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xbar_router.md
XBAR_ROUTER -- requirements
Module: xbar_router

Interface
REQ-001 Parameter WIDTH, default 32, payload bit width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in0_valid / in1_valid  input  1  source i offers a beat.
REQ-005 in0_ready / in1_ready  output  1  beat on source i accepted this cycle.
REQ-006 in0_dest / in1_dest  input  1  target output port (0 or 1).
REQ-007 in0_data / in1_data  input  WIDTH  payload.
REQ-008 out0_valid / out1_valid  output  1  output k holds a beat.
REQ-009 out0_ready / out1_ready  input  1  sink k consumes the beat.
REQ-010 out0_data / out1_data  output  WIDTH  payload.
REQ-011 out0_src / out1_src  output  1  index of the input that supplied the beat.

Function
REQ-012 A transfer on any port SHALL occur exactly when valid and ready are both high at a rising clk edge.
REQ-013 Each output k SHALL own a one-entry register holding valid, data and src.
REQ-014 Requesters of output k SHALL be the inputs with valid=1 and dest=k.
REQ-015 Output k SHALL be able to load when its register is empty, or when it is full and out_k_ready=1 (same-cycle drain and refill).
REQ-016 Output k SHALL grant at most one requester per cycle, and only when it is able to load.
REQ-017 With one requester, output k SHALL grant that requester.
REQ-018 With two requesters, output k SHALL grant the input named by its round-robin pointer.
REQ-019 After any grant, output k's pointer SHALL point to the non-granted input; with no grant, the pointer SHALL hold.
REQ-020 in_i_ready SHALL be 1 exactly when the output addressed by in_i_dest grants input i; it SHALL be combinational from valid, dest, out ready and register state.
REQ-021 in_i_ready SHALL NOT depend on in_i_valid except through the request decode; a non-requesting input SHALL see ready=0.
REQ-022 Latency SHALL be one cycle: a beat accepted at edge N SHALL be visible on out_k_* after edge N.
REQ-023 Throughput SHALL be one beat per output per cycle, and two beats per cycle when the inputs target different outputs.
REQ-024 Outputs SHALL be independent; a stalled out0 SHALL NOT block input traffic to out1.
REQ-025 While out_k_valid=1 and out_k_ready=0, out_k_data and out_k_src SHALL hold stable.
REQ-026 When a full register drains with no new grant, out_k_valid SHALL fall to 0 on that edge.
REQ-027 Beats from the same input to the same output SHALL leave in acceptance order.
REQ-028 Under continuous contention, grants SHALL alternate 0,1,0,1...; no input SHALL starve.

Reset
REQ-029 While rst=1 at a clk edge: out0_valid=out1_valid=0, out_k_data=0, out_k_src=0, and both pointers=input 0.
REQ-030 Reset mid-transfer SHALL discard held beats; in_i_ready SHALL read 0 while rst=1.
REQ-031 First grants after reset release SHALL favour input 0 on contention.

Structure
REQ-032 Shared package xbar_pkg SHALL hold port_idx_t (1-bit port index), NUM_PORTS=2, and the beat struct {data, src}.
REQ-033 Sub-module xbar_out_port SHALL implement one output's request decode, round-robin pointer, grant and register, and SHALL be instantiated twice.
REQ-034 The top level SHALL OR per-output grants into in_i_ready.

Verification
REQ-035 Reset, then in0 valid dest=1 data=0xA5A5A5A5, out1_ready=1 -> in0_ready=1 that cycle; next cycle out1_valid=1, data=0xA5A5A5A5, src=0; out0_valid stays 0.
REQ-036 Both inputs valid dest=0 (0x11, 0x22) for 4 cycles, out0_ready=1 -> out0 data sequence 0x11,0x22,0x11,0x22 with src 0,1,0,1.
REQ-037 in0 dest=0 and in1 dest=1 in the same cycle -> both ready=1; next cycle both outputs valid with the correct data and src.
REQ-038 out0 full, out0_ready=0, in0 dest=0 valid -> in0_ready=0 and out0_data stable for 5 cycles; then out0_ready=1 -> drain and refill on the same edge, out0_valid stays 1.
REQ-039 rst asserted while out1 holds a beat and in1 is requesting -> next cycle out1_valid=0, in1_ready=0; after release, contention grants input 0 first.
REQ-040 Random valid/dest/ready for 10k cycles with a scoreboard -> no loss, no duplication, per-source order preserved, src correct.
